// File: rtl/core_run_ctrl.sv
// Run sequencer for CORE instances: arm delay, level start, halt collection,
// cycle-budget watchdog and registered status reporting.
module core_run_ctrl #(
  parameter int unsigned NCORE   = 1,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned ARM_DLY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [NCORE-1:0] core_halt,
  output logic [NCORE-1:0] core_start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [NCORE-1:0] halted_mask,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned   AW      = (ARM_DLY > 1) ? $clog2(ARM_DLY + 1) : 1;
  localparam logic [CW-1:0] CYC_MAX = '1;
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT);
  localparam logic [AW-1:0] ARM_LIM = AW'(ARM_DLY);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    arm_cnt, arm_cnt_nx;
  logic [CW-1:0]    cyc, cyc_nx, cyc_inc;
  logic [NCORE-1:0] mask, mask_nx, mask_upd;
  logic             to, to_nx;
  logic             start_q, busy_q, done_q;

  always_comb begin
    state_nx   = state;
    arm_cnt_nx = arm_cnt;
    cyc_nx     = cyc;
    mask_nx    = mask;
    to_nx      = to;
    mask_upd   = mask | core_halt;
    cyc_inc    = (cyc == CYC_MAX) ? cyc : cyc + 1'b1;

    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_nx   = (ARM_DLY > 0) ? ARM : RUN;
          arm_cnt_nx = '0;
          cyc_nx     = '0;
          mask_nx    = '0;
          to_nx      = 1'b0;
        end
      end
      ARM: begin
        arm_cnt_nx = arm_cnt + 1'b1;
        if (arm_cnt_nx == ARM_LIM) state_nx = RUN;
      end
      RUN: begin
        cyc_nx  = cyc_inc;
        mask_nx = mask_upd;
        // Full mask is tested first so a last halt on the budget edge wins.
        if (&mask_upd) begin
          state_nx = DONE;
        end else if (cyc_inc == TO_LIM) begin
          state_nx = DONE;
          to_nx    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      arm_cnt <= '0;
      cyc     <= '0;
      mask    <= '0;
      to      <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      arm_cnt <= arm_cnt_nx;
      cyc     <= cyc_nx;
      mask    <= mask_nx;
      to      <= to_nx;
      start_q <= (state_nx == RUN);
      busy_q  <= (state_nx == ARM) || (state_nx == RUN);
      done_q  <= (state_nx == DONE);
    end
  end

  assign core_start  = {NCORE{start_q}};
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = to;
  assign halted_mask = mask;
  assign cycles      = cyc;

endmodule
